alu_operand_mux_pipe: RTL and testbench
=======================================

// Module: alu_operand_mux_pipe
//
// PURPOSE
//  Parametrised N-way ALU operand selector with a registered valid/ready output stage.
//  Successor of the 2:1 32-bit combinational operand mux.
//  - Selects one of NUM_INPUTS words (register data, immediate, forwarded EX/MEM/WB results).
//  - Presents the selected word to the ALU one cycle later.
//  - A 2-entry skid buffer lets the pipeline stall through out_ready without a combinational
//    ready path.
//
// PARAMETERS
//  WIDTH      32  data width of each input and of the output, in bits
//  NUM_INPUTS 4   number of selectable inputs; must be >= 2
//  SEL_W      2   select width, equal to $clog2(NUM_INPUTS); must be >= 1
//
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 synchronous reset, active high
//  flush      in   1                 synchronous flush: discards buffered operands
//  in_data    in   NUM_INPUTS*WIDTH  flattened inputs; input i = in_data[i*WIDTH +: WIDTH]
//  in_sel     in   SEL_W             binary select, sampled with in_data
//  in_valid   in   1                 in_data/in_sel are valid this cycle
//  in_ready   out  1                 block can accept an operand this cycle (registered)
//  out_data   out  WIDTH             selected operand
//  out_err    out  1                 1 when in_sel was >= NUM_INPUTS; out_data is 0 in that case
//  out_valid  out  1                 out_data/out_err are valid
//  out_ready  in   1                 consumer (ALU stage) accepts out_data this cycle
//
// BEHAVIOUR
//  - Accept condition: acc = in_valid & in_ready.
//  - Output condition: pop = out_valid & out_ready.
//  - Select:
//      sel_word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_INPUTS, else {WIDTH{1'b0}}.
//      err = (in_sel >= NUM_INPUTS).
//  - Storage:
//      main entry {out_data, out_err, out_valid}.
//      skid entry {skid_data, skid_err, skid_valid}.
//  - in_ready = ~skid_valid, driven from a flop. No combinational path from out_ready to in_ready.
//  - Each clock edge, in priority order:
//     1. rst: out_valid=0, skid_valid=0, out_data=0, out_err=0, skid_data=0, skid_err=0.
//        in_ready reads 1 from the cycle after reset.
//     2. flush: out_valid=0 and skid_valid=0. Data registers are left unchanged.
//        An input offered in the flush cycle is dropped.
//     3. Main entry free or popping (~out_valid | out_ready):
//        a. skid_valid=1: main <= skid; skid_valid <= 0.
//           No accept is possible here because in_ready=0.
//        b. else: main <= {sel_word, err}; out_valid <= acc.
//     4. Main entry stalled (out_valid & ~out_ready) and acc:
//        skid <= {sel_word, err}; skid_valid <= 1.
//     5. Otherwise all state holds.
//  - Timing and ordering:
//      Latency is exactly 1 cycle from acc to out_valid when the output is not stalled.
//      Throughput is 1 operand/cycle while out_ready=1.
//      Operands leave in acceptance order. None is lost or duplicated.
//  - Stall: while out_valid & ~out_ready, out_data and out_err are held stable.
//  - Full: with both entries occupied, in_ready=0. After the first pop, in_ready returns to 1
//    on the next cycle.
//  - Ignored input: in_sel and in_data are ignored whenever acc=0.
//  - Out-of-range select: the operand is still accepted and delivered with out_err=1 and
//    out_data=0.
//  - Reset mid-operation: both entries are discarded. No output is produced for operands that
//    were in flight.
//
// TESTING
//  1. Reset, defaults (WIDTH=32, NUM_INPUTS=4):
//     rst=1 for 2 cycles, then release.
//     -> out_valid=0, out_data=0, out_err=0, in_ready=1.
//  2. Streaming:
//     inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, in_sel=0,1,2,3 on consecutive
//     cycles, out_ready=1.
//     -> out_data = 0x11111111..0x44444444 exactly one cycle after each accept, out_err=0.
//  3. Stall/skid:
//     hold out_ready=0, offer sel=1 then sel=2 on back-to-back cycles.
//     -> both accepted; in_ready=0 afterwards; out_data holds 0x22222222.
//     Raise out_ready.
//     -> 0x33333333 follows on the next cycle; in_ready=1 one cycle after the first pop.
//  4. Out of range (NUM_INPUTS=3, SEL_W=2):
//     in_sel=3, in_valid=1.
//     -> next cycle out_valid=1, out_err=1, out_data=0.
//  5. Flush and reset:
//     fill both entries with out_ready=0, then pulse flush (repeat with rst instead).
//     -> out_valid=0 and in_ready=1 the following cycle; no stale operand ever appears.
//  6. Random backpressure:
//     10k cycles of random in_valid/out_ready/in_sel.
//     -> scoreboard confirms in-order, lossless, duplicate-free delivery matching the select
//        model.

Source files
------------

// File: rtl/alu_operand_mux_pipe.sv
// N-way ALU operand selector feeding a registered valid/ready output stage.
// A second (skid) entry absorbs one operand during a stall, so in_ready never depends on out_ready combinationally.
module alu_operand_mux_pipe #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_err,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic             acc;

  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic             rdy_q, rdy_d;

  // Out-of-range selects fall through the loop and leave sel_word at zero.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_err = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_INPUTS));
  assign acc     = in_valid & rdy_q;

  always_comb begin
    data_d       = data_q;
    err_d        = err_q;
    valid_d      = valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!valid_q || out_ready) begin
      if (skid_valid_q) begin
        data_d       = skid_data_q;
        err_d        = skid_err_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        data_d  = sel_word;
        err_d   = sel_err;
        valid_d = acc;
      end
    end else if (acc) begin
      skid_data_d  = sel_word;
      skid_err_d   = sel_err;
      skid_valid_d = 1'b1;
    end

    // Ready flop tracks the next skid occupancy so it is a pure register output.
    rdy_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b1;
    end else begin
      data_q       <= data_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_operand_mux_pipe.sv
// Scoreboard bench: a 4-input and a 3-input instance share stimulus; expected
// operands are queued on accept and checked by a monitor on every pop.
module tb_alu_operand_mux_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_err, out_valid;
  logic [31:0]  out_data;
  logic         in_ready3, out_err3, out_valid3;
  logic [31:0]  out_data3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] q4[$];
  logic [32:0] q3[$];
  logic        stall4 = 1'b0;
  logic [31:0] hold4 = '0;

  always #5 clk = ~clk;

  alu_operand_mux_pipe #(.WIDTH(32), .NUM_INPUTS(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  alu_operand_mux_pipe #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data[95:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
    .out_err(out_err3), .out_valid(out_valid3), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [127:0] d, input logic [1:0] s, input int n);
    if (int'(s) < n) return {1'b0, d[s*32 +: 32]};
    return {1'b1, 32'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, where inputs and outputs are stable
  // and equal to what the next rising edge will act upon.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst || flush) begin
      q4.delete();
      q3.delete();
      stall4 = 1'b0;
    end else begin
      if (stall4) begin
        check("stall_hold_data", 64'(out_data), 64'(hold4));
        check("stall_hold_valid", 64'(out_valid), 64'd1);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("FAIL sb4_unexpected: got output %0h expected no output (t=%0t)", out_data, $time);
        end else begin
          e = q4.pop_front();
          check("sb4_data", 64'(out_data), 64'(e[31:0]));
          check("sb4_err", 64'(out_err), 64'(e[32]));
        end
      end
      if (out_valid3 && out_ready) begin
        n_checks++;
        if (q3.size() == 0) begin
          n_fail++;
          $display("FAIL sb3_unexpected: got output %0h expected no output (t=%0t)", out_data3, $time);
        end else begin
          e = q3.pop_front();
          check("sb3_data", 64'(out_data3), 64'(e[31:0]));
          check("sb3_err", 64'(out_err3), 64'(e[32]));
        end
      end
      if (in_valid && in_ready)  q4.push_back(model(in_data, in_sel, 4));
      if (in_valid && in_ready3) q3.push_back(model(in_data, in_sel, 3));
      stall4 = out_valid && !out_ready;
      hold4  = out_data;
    end
  end

  localparam logic [127:0] VEC = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  initial begin
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222;
    exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;

    // Reset defaults
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming, one cycle latency
    in_data = VEC;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      in_valid = 1'b1;
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", 64'(out_data), 64'(exp_w[i]));
      check("stream_err", 64'(out_err), 64'd0);
    end
    in_valid = 1'b0;
    step();
    check("stream_idle_valid", 64'(out_valid), 64'd0);

    // Stall and skid
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'd1;
    step();
    in_sel = 2'd2;
    step();
    in_valid = 1'b0;
    check("skid_in_ready_full", 64'(in_ready), 64'd0);
    check("skid_hold_data", 64'(out_data), 64'h22222222);
    step();
    check("skid_still_held", 64'(out_data), 64'h22222222);
    check("skid_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    check("skid_second_data", 64'(out_data), 64'h33333333);
    check("skid_second_valid", 64'(out_valid), 64'd1);
    check("skid_ready_back", 64'(in_ready), 64'd1);
    step();
    check("skid_drained", 64'(out_valid), 64'd0);

    // Out-of-range select on the 3-input instance
    in_sel = 2'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("oor_valid", 64'(out_valid3), 64'd1);
    check("oor_err", 64'(out_err3), 64'd1);
    check("oor_data", 64'(out_data3), 64'd0);
    check("inrange_err", 64'(out_err), 64'd0);
    check("inrange_data", 64'(out_data), 64'h44444444);
    step();

    // Flush, then reset, with both entries occupied and an input offered
    for (int pass = 0; pass < 2; pass++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_sel = 2'd0;
      step();
      in_sel = 2'd1;
      step();
      check("fill_full", 64'(in_ready), 64'd0);
      in_sel = 2'd2;
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      step();
      flush = 1'b0;
      rst = 1'b0;
      in_valid = 1'b0;
      check(pass == 0 ? "flush_valid" : "rstmid_valid", 64'(out_valid), 64'd0);
      check(pass == 0 ? "flush_ready" : "rstmid_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        check("no_stale_valid", 64'(out_valid), 64'd0);
        check("no_stale_valid3", 64'(out_valid3), 64'd0);
      end
    end

    // Random backpressure
    for (int c = 0; c < 10000; c++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (q4.size() != 0 || q3.size() != 0); k++) step();
    step();
    check("drain_q4_empty", 64'(q4.size()), 64'd0);
    check("drain_q3_empty", 64'(q3.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
